// File: rtl/chaos_seq_ctrl_pkg.sv
// Shared definitions for the logistic-map sequencer: state encoding,
// Q8.8 constants and the seed sanitise / reseed helpers.
package chaos_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  localparam logic [15:0] Q_ONE       = 16'h0100;
  localparam logic [15:0] Q_HALF      = 16'h0080;
  localparam logic [7:0]  RESEED_STEP = 8'd37;

  // A seed of zero is a fixed point and anything at or above 1.0 leaves the
  // unit interval, so both are replaced by 0.5.
  function automatic logic [15:0] sanitize_seed(input logic [15:0] s);
    logic [15:0] res;
    if ((s == 16'h0000) || (s >= Q_ONE)) begin
      res = Q_HALF;
    end else begin
      res = s;
    end
    return res;
  endfunction

  // Step the fractional part of the seed; a zero result would reseed straight
  // into the collapsed orbit, so it is bumped to the smallest non-zero value.
  function automatic logic [15:0] next_seed(input logic [15:0] s);
    logic [7:0] lo;
    lo = s[7:0] + RESEED_STEP;
    if (lo == 8'h00) begin
      lo = 8'h01;
    end else begin
      lo = lo;
    end
    return {8'h00, lo};
  endfunction

endpackage

// File: rtl/chaos_seq_ctrl_stuck_det.sv
// Collapsed-orbit detector: remembers the last accepted map state and counts
// how many accepted samples in a row repeated it. Flags a hit when the
// accepted sample is zero or the repeat run reaches STUCK_LIMIT-1.
module chaos_seq_ctrl_stuck_det
  import chaos_seq_ctrl_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int STUCK_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             accept,
  input  logic [WIDTH-1:0] sample,
  output logic             hit
);

  localparam int SAME_W = (STUCK_LIMIT > 1) ? $clog2(STUCK_LIMIT) : 1;
  localparam int SAME_LAST_I = (STUCK_LIMIT > 1) ? (STUCK_LIMIT - 1) : 0;
  localparam logic [SAME_W-1:0] SAME_LAST = SAME_LAST_I[SAME_W-1:0];

  logic [WIDTH-1:0]  last_q, last_d;
  logic              last_vld_q, last_vld_d;
  logic [SAME_W-1:0] same_cnt_q, same_cnt_d;
  logic [SAME_W-1:0] same_next_s;
  logic              repeat_s;

  // Next repeat count and hit decision for the sample being accepted now.
  always_comb begin
    repeat_s    = last_vld_q && (sample == last_q);
    if (repeat_s) begin
      same_next_s = same_cnt_q + SAME_W'(1'b1);
    end else begin
      same_next_s = '0;
    end
    hit = accept && ((sample == '0) || (same_next_s == SAME_LAST));
  end

  // History update: a load forgets the previous orbit, an accept records it.
  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    same_cnt_d = same_cnt_q;
    if (clear) begin
      last_vld_d = 1'b0;
      same_cnt_d = '0;
    end else if (accept) begin
      last_d     = sample;
      last_vld_d = 1'b1;
      same_cnt_d = same_next_s;
    end else begin
      last_vld_d = last_vld_q;
    end
  end

  // History registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
      same_cnt_q <= '0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      same_cnt_q <= same_cnt_d;
    end
  end

endmodule

// File: rtl/chaos_seq_ctrl.sv
// Sequencer for the Q8.8 logistic-map core: loads seed and r, discards the
// warm-up transient, streams fractional sample bytes over valid/ready and
// reseeds automatically when the orbit collapses.
module chaos_seq_ctrl
  import chaos_seq_ctrl_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FRAC        = 8,
  parameter int OUT_W       = 8,
  parameter int WARMUP      = 64,
  parameter int STUCK_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] r_param,
  input  logic [15:0]      len,
  output logic             map_load,
  output logic             map_en,
  output logic [WIDTH-1:0] map_x_init,
  output logic [WIDTH-1:0] map_r,
  input  logic [WIDTH-1:0] map_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             stuck
);

  localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int WARM_LAST_I = (WARMUP > 0) ? (WARMUP - 1) : 0;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_LAST_I[WARM_W-1:0];

  state_e            state_q, state_d, run_next_s;
  logic [WIDTH-1:0]  seed_q, seed_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       sample_cnt_q, sample_cnt_d, cnt_inc_s;
  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic              map_load_q, map_load_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              stuck_q, stuck_d;
  logic              handshake_s;
  logic              stuck_hit_s;

  // The core only advances on a handshake in RUN, so out_data holds under
  // backpressure without any extra sample register.
  assign out_valid   = (state_q == ST_RUN);
  assign handshake_s = out_valid && out_ready;
  assign map_en      = (state_q == ST_WARMUP) || handshake_s;
  assign out_data    = map_out[FRAC-1 -: OUT_W];

  assign map_load   = map_load_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign stuck      = stuck_q;
  assign map_x_init = seed_q;
  assign map_r      = r_q;

  chaos_seq_ctrl_stuck_det #(
    .WIDTH       (WIDTH),
    .STUCK_LIMIT (STUCK_LIMIT)
  ) u_stuck_det (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == ST_LOAD),
    .accept (handshake_s),
    .sample (map_out),
    .hit    (stuck_hit_s)
  );

  // Next-state, counter and registered-output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    run_next_s   = ST_RUN;
    seed_d       = seed_q;
    r_d          = r_q;
    len_d        = len_q;
    sample_cnt_d = sample_cnt_q;
    warm_cnt_d   = warm_cnt_q;
    stuck_d      = stuck_q;
    done_d       = 1'b0;
    cnt_inc_s    = sample_cnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          r_d          = r_param;
          len_d        = len;
          seed_d       = sanitize_seed(seed);
          stuck_d      = 1'b0;
          sample_cnt_d = 16'd0;
          state_d      = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        warm_cnt_d = '0;
        if (stop) begin
          state_d = ST_IDLE;
        end else if (WARMUP == 0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_WARMUP;
        end
      end

      ST_WARMUP: begin
        warm_cnt_d = warm_cnt_q + WARM_W'(1'b1);
        if (stop) begin
          state_d = ST_IDLE;
        end else if (warm_cnt_q == WARM_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_WARMUP;
        end
      end

      ST_RUN: begin
        if (handshake_s) begin
          sample_cnt_d = cnt_inc_s;
          if ((len_q != 16'd0) && (cnt_inc_s == len_q)) begin
            // Completing the stream beats a simultaneous reseed.
            done_d     = 1'b1;
            stuck_d    = stuck_q || stuck_hit_s;
            run_next_s = ST_IDLE;
          end else if (stuck_hit_s) begin
            stuck_d    = 1'b1;
            seed_d     = next_seed(seed_q);
            run_next_s = ST_LOAD;
          end else begin
            run_next_s = ST_RUN;
          end
        end else begin
          run_next_s = ST_RUN;
        end
        state_d = stop ? ST_IDLE : run_next_s;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    map_load_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
  end

  // State, captured configuration, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      seed_q       <= '0;
      r_q          <= '0;
      len_q        <= 16'd0;
      sample_cnt_q <= 16'd0;
      warm_cnt_q   <= '0;
      map_load_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      r_q          <= r_d;
      len_q        <= len_d;
      sample_cnt_q <= sample_cnt_d;
      warm_cnt_q   <= warm_cnt_d;
      map_load_q   <= map_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      stuck_q      <= stuck_d;
    end
  end

endmodule

// File: tb/tb_chaos_seq_ctrl.sv
// Bench for chaos_seq_ctrl: a behavioural logistic-map core drives map_out,
// and expected sample streams come from iterating the map directly.
module tb_chaos_seq_ctrl;

  localparam int WARM  = 4;
  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic [15:0] seed;
  logic [15:0] r_param;
  logic [15:0] len;
  logic        map_load;
  logic        map_en;
  logic [15:0] map_x_init;
  logic [15:0] map_r;
  logic [15:0] map_out;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;
  logic        done;
  logic        stuck;

  int errors = 0;
  int checks = 0;

  logic [15:0] core_x = 16'h0000;
  logic        force_zero = 1'b0;

  chaos_seq_ctrl #(
    .WIDTH(16), .FRAC(8), .OUT_W(8), .WARMUP(WARM), .STUCK_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .seed(seed),
    .r_param(r_param), .len(len), .map_load(map_load), .map_en(map_en),
    .map_x_init(map_x_init), .map_r(map_r), .map_out(map_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .stuck(stuck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // x' = r*x*(1-x) with all three factors in Q8.8
  function automatic logic [15:0] lmap(input logic [15:0] x, input logic [15:0] r);
    longint p;
    p = longint'(r) * longint'(x) * (longint'(256) - longint'(x));
    p = p / 65536;
    if (p < 0) p = 0;
    return p[15:0];
  endfunction

  function automatic logic [15:0] warm_m(input logic [15:0] x0, input logic [15:0] r);
    logic [15:0] x;
    x = x0;
    for (int i = 0; i < WARM; i++) x = lmap(x, r);
    return x;
  endfunction

  function automatic logic [15:0] sanitize_m(input logic [15:0] s);
    int v;
    v = int'(s);
    if (v == 0 || v >= 256) v = 128;
    return 16'(v);
  endfunction

  function automatic logic [15:0] reseed_m(input logic [15:0] s);
    int v;
    v = (int'(s) % 256 + 37) % 256;
    if (v == 0) v = 1;
    return 16'(v);
  endfunction

  // Behavioural map core
  always @(posedge clk) begin
    if (map_load) core_x <= map_x_init;
    else if (map_en) core_x <= lmap(core_x, map_r);
  end
  assign map_out = force_zero ? 16'h0000 : core_x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] s, input logic [15:0] r, input logic [15:0] l);
    seed = s; r_param = r; len = l; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_valid;
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("wait_valid", {31'd0, out_valid}, 32'd1);
  endtask

  // Random-ready stream checked against a direct iteration of the map
  task automatic run_model(input logic [15:0] s, input logic [15:0] r, input logic [15:0] l);
    logic [15:0] sm, x, prev;
    int rep, rep_new, cnt;
    bit pv, hit, exp_stuck, fin;
    out_ready = 1'b0;
    do_start(s, r, l);
    sm = sanitize_m(s); x = warm_m(sm, r);
    cnt = 0; pv = 0; rep = 0; exp_stuck = 0; fin = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        chk("rnd_data", {24'd0, out_data}, {24'd0, x[7:0]});
        cnt++;
        rep_new = (pv && x == prev) ? rep + 1 : 0;
        hit = (x == 16'h0000) || (rep_new == LIMIT - 1);
        if (l != 16'd0 && cnt == int'(l)) begin
          fin = 1;
          if (hit) exp_stuck = 1;
        end else if (hit) begin
          exp_stuck = 1;
          sm = reseed_m(sm); x = warm_m(sm, r); pv = 0; rep = 0;
        end else begin
          prev = x; pv = 1; rep = rep_new; x = lmap(x, r);
        end
      end
      step();
      if (fin) begin
        chk("rnd_done", {31'd0, done}, 32'd1);
        chk("rnd_busy_after_done", {31'd0, busy}, 32'd0);
      end else if (done) begin
        chk("rnd_early_done", {31'd0, done}, 32'd0);
      end
    end
    chk("rnd_finished", {31'd0, fin}, 32'd1);
    chk("rnd_stuck", {31'd0, stuck}, {31'd0, exp_stuck});
    out_ready = 1'b0;
    step();
  endtask

  typedef struct {
    logic [15:0] seed;
    logic [15:0] r;
    logic [15:0] exp_init;
  } seed_vec_t;

  initial begin
    seed_vec_t tbl[6];
    logic [15:0] x;
    int en_cnt, hs_cnt, first_hs, last_hs;
    bit got_done, any_valid, any_done;

    tbl[0] = '{16'h0000, 16'h0300, 16'h0080};
    tbl[1] = '{16'h0180, 16'h0310, 16'h0080};
    tbl[2] = '{16'h0100, 16'h0320, 16'h0080};
    tbl[3] = '{16'h00FF, 16'h0330, 16'h00FF};
    tbl[4] = '{16'h0001, 16'h0340, 16'h0001};
    tbl[5] = '{16'hFFFF, 16'h03E6, 16'h0080};

    reset = 1'b1; start = 1'b0; stop = 1'b0; seed = 16'h0; r_param = 16'h0;
    len = 16'h0; out_ready = 1'b0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_x_init", {16'd0, map_x_init}, 32'd0);
    reset = 1'b0;
    step();

    // Seed sanitising and parameter capture at LOAD
    for (int i = 0; i < 6; i++) begin
      do_start(tbl[i].seed, tbl[i].r, 16'd5);
      chk("tbl_map_load", {31'd0, map_load}, 32'd1);
      chk("tbl_x_init", {16'd0, map_x_init}, {16'd0, tbl[i].exp_init});
      chk("tbl_map_r", {16'd0, map_r}, {16'd0, tbl[i].r});
      chk("tbl_busy", {31'd0, busy}, 32'd1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("tbl_stop_idle", {31'd0, busy}, 32'd0);
    end

    // Basic stream: warm-up length, back-to-back handshakes, done pulse
    out_ready = 1'b1;
    do_start(16'd128, 16'd998, 16'd3);
    chk("t2_load", {31'd0, map_load}, 32'd1);
    chk("t2_load_no_en", {31'd0, map_en}, 32'd0);
    x = warm_m(16'd128, 16'd998);
    en_cnt = 0; hs_cnt = 0; first_hs = -1; last_hs = -1; got_done = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc == 1) chk("t2_load_1cyc", {31'd0, map_load}, 32'd0);
      if (map_en && !out_valid) en_cnt++;
      if (out_valid && out_ready) begin
        chk("t2_data", {24'd0, out_data}, {24'd0, x[7:0]});
        x = lmap(x, 16'd998);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
      end
      step();
      if (done) begin
        chk("t2_busy_low", {31'd0, busy}, 32'd0);
        got_done = 1;
        break;
      end
    end
    chk("t2_got_done", {31'd0, got_done}, 32'd1);
    chk("t2_warm_en", en_cnt, 32'd4);
    chk("t2_hs_cnt", hs_cnt, 32'd3);
    chk("t2_b2b", last_hs - first_hs, 32'd2);
    step();
    chk("t2_done_pulse", {31'd0, done}, 32'd0);

    // Backpressure: core frozen, data stable, count unaffected
    out_ready = 1'b0;
    do_start(16'h0033, 16'h0390, 16'd3);
    wait_valid();
    x = warm_m(16'h0033, 16'h0390);
    for (int i = 0; i < 5; i++) begin
      chk("t3_en_low", {31'd0, map_en}, 32'd0);
      chk("t3_data_hold", {24'd0, out_data}, {24'd0, x[7:0]});
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("t3_en_high", {31'd0, map_en}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_data", {24'd0, out_data}, {24'd0, x[7:0]});
      x = lmap(x, 16'h0390);
      step();
      if (i < 2) chk("t3_no_done_yet", {31'd0, done}, 32'd0);
    end
    chk("t3_done", {31'd0, done}, 32'd1);
    out_ready = 1'b0;
    step();

    // Stop during warm-up
    out_ready = 1'b1;
    do_start(16'h0060, 16'h03A0, 16'd2);
    step();
    chk("t6_in_warmup", {31'd0, map_en}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t6_idle", {31'd0, busy}, 32'd0);
    any_valid = 0; any_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) any_valid = 1;
      if (done) any_done = 1;
      step();
    end
    chk("t6_no_valid", {31'd0, any_valid}, 32'd0);
    chk("t6_no_done", {31'd0, any_done}, 32'd0);
    out_ready = 1'b0;

    // Forced zero orbit -> reseed to 0x80+37
    do_start(16'd128, 16'd998, 16'd0);
    wait_valid();
    force_zero = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t5_zero_data", {24'd0, out_data}, 32'd0);
    step();
    force_zero = 1'b0;
    out_ready = 1'b0;
    chk("t5_stuck", {31'd0, stuck}, 32'd1);
    chk("t5_reload", {31'd0, map_load}, 32'd1);
    chk("t5_x_init", {16'd0, map_x_init}, 32'h0000_00A5);
    chk("t5_busy", {31'd0, busy}, 32'd1);

    // Asynchronous reset mid-RUN
    wait_valid();
    #2;
    reset = 1'b1;
    #1;
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_stuck", {31'd0, stuck}, 32'd0);
    chk("t1_map_r", {16'd0, map_r}, 32'd0);
    step(); step();
    chk("t1_hold_load", {31'd0, map_load}, 32'd0);
    chk("t1_hold_en", {31'd0, map_en}, 32'd0);
    chk("t1_hold_done", {31'd0, done}, 32'd0);
    chk("t1_hold_x_init", {16'd0, map_x_init}, 32'd0);
    reset = 1'b0;
    step();

    // Fixed point at 0.5 for r=2.0: repeated samples trigger reseeds
    run_model(16'h0080, 16'h0200, 16'd10);

    // Randomised streams
    for (int k = 0; k < 12; k++) begin
      run_model(16'($urandom), 16'($urandom_range(16'h0200, 16'h03FF)),
                16'($urandom_range(1, 12)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
